// File: rtl/control_motor_pasos_param_pkg.sv
// Shared encodings and coil-table helpers for the stepper controller.
// Combinational helpers only; no latency.
// No handshake; callers apply the results on their own clock edges.
package control_motor_pasos_param_pkg;

  localparam logic [1:0] MODO_SIMPLE    = 2'b00;
  localparam logic [1:0] MODO_DOBLE     = 2'b01;
  localparam logic [1:0] MODO_MEDIO     = 2'b10;
  localparam logic [1:0] MODO_RESERVADO = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } estado_t;

  // Eight-phase half-step table; bit 3 = coil A, bit 0 = coil D.
  function automatic logic [3:0] patron_bobinas(input logic [2:0] idx);
    logic [3:0] p;
    case (idx)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Single mode lives on even indices, double on odd ones; half keeps the index.
  function automatic logic [2:0] alinear_idx(input logic [1:0] modo, input logic [2:0] idx);
    logic [2:0] r;
    case (modo)
      MODO_SIMPLE: r = {idx[2:1], 1'b0};
      MODO_DOBLE:  r = {idx[2:1], 1'b1};
      default:     r = idx;
    endcase
    return r;
  endfunction

  // One step: +-1 in half mode, +-2 otherwise; 3-bit arithmetic gives the mod-8 wrap.
  function automatic logic [2:0] avanzar_idx(input logic [1:0] modo, input logic dir,
                                             input logic [2:0] idx);
    logic [2:0] inc;
    inc = (modo == MODO_MEDIO) ? 3'd1 : 3'd2;
    return dir ? (idx + inc) : (idx - inc);
  endfunction

endpackage

// File: rtl/divisor_pasos.sv
// Loadable down-counter producing the step-due tick for the stepper controller.
// Tick is combinational from the count: high while enabled and the count is zero.
// No backpressure; load has priority over counting, counting stops at zero.
module divisor_pasos #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 frecuencia,
  input  logic                 rst_n,
  input  logic                 cargar,
  input  logic                 habilitar,
  input  logic [DIV_WIDTH-1:0] valor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cuenta;

  // Reload on request, otherwise count down towards zero while enabled.
  always_ff @(posedge frecuencia or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= valor;
    end else if (habilitar && (cuenta != '0)) begin
      cuenta <= cuenta - DIV_WIDTH'(1);
    end
  end

  assign tick = habilitar && (cuenta == '0);

endmodule

// File: rtl/control_motor_pasos_param.sv
// Stepper controller: wave/full/half sequences, programmable step period, counted or continuous moves.
// Start energises on the accepting edge; step N lands P*N edges later together with done.
// No backpressure; start is ignored while busy, stop aborts immediately and wins over a due step.
module control_motor_pasos_param
  import control_motor_pasos_param_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 frecuencia,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           modo,
  input  logic                 direccionGiro,
  input  logic                 continuo,
  input  logic [DIV_WIDTH-1:0] periodo,
  input  logic [CNT_WIDTH-1:0] numPasos,
  input  logic                 retener,
  output logic [3:0]           salidaMotor,
  output logic                 ledDireccion,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pasosRestantes
);

  estado_t              estado;
  logic [2:0]           idx;
  logic [1:0]           modo_lat;
  logic                 dir_lat;
  logic                 continuo_lat;
  logic [DIV_WIDTH-1:0] periodo_lat;
  // Set by the first move after reset so retener never drives coils straight out of reset.
  logic                 energizado;

  logic                 arranque;
  logic                 acepta;
  logic                 paso;
  logic                 tick;
  logic                 div_cargar;
  logic [DIV_WIDTH-1:0] periodo_ef;
  logic [DIV_WIDTH-1:0] div_valor;

  // Decode start acceptance, step execution and divider reload.
  always_comb begin
    periodo_ef = (periodo == '0) ? DIV_WIDTH'(1) : periodo;
    arranque   = (estado == IDLE) && start && !stop && (modo != MODO_RESERVADO);
    acepta     = arranque && (continuo || (numPasos != '0));
    paso       = (estado == RUN) && !stop && tick;
    div_cargar = acepta || paso;
    div_valor  = acepta ? (periodo_ef - DIV_WIDTH'(1)) : (periodo_lat - DIV_WIDTH'(1));
  end

  divisor_pasos #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_divisor (
    .frecuencia(frecuencia),
    .rst_n     (rst_n),
    .cargar    (div_cargar),
    .habilitar (estado == RUN),
    .valor     (div_valor),
    .tick      (tick)
  );

  // Move sequencer: latch the request, walk the phase table, count steps, pulse done.
  always_ff @(posedge frecuencia or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= IDLE;
      idx            <= 3'd0;
      modo_lat       <= MODO_SIMPLE;
      dir_lat        <= 1'b0;
      continuo_lat   <= 1'b0;
      periodo_lat    <= DIV_WIDTH'(1);
      energizado     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pasosRestantes <= '0;
    end else begin
      done <= 1'b0;
      if (estado == IDLE) begin
        if (acepta) begin
          estado         <= RUN;
          busy           <= 1'b1;
          energizado     <= 1'b1;
          modo_lat       <= modo;
          dir_lat        <= direccionGiro;
          continuo_lat   <= continuo;
          periodo_lat    <= periodo_ef;
          pasosRestantes <= numPasos;
          idx            <= alinear_idx(modo, idx);
        end else if (arranque) begin
          // Zero-length request: acknowledge without moving.
          done <= 1'b1;
        end
      end else begin
        if (stop) begin
          estado <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end else if (paso) begin
          idx <= avanzar_idx(modo_lat, dir_lat, idx);
          if (!continuo_lat) begin
            pasosRestantes <= pasosRestantes - CNT_WIDTH'(1);
            if (pasosRestantes == CNT_WIDTH'(1)) begin
              estado <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Coils follow the table while running; in idle only when holding torque is requested.
  always_comb begin
    salidaMotor  = 4'b0000;
    if ((estado == RUN) || (retener && energizado)) begin
      salidaMotor = patron_bobinas(idx);
    end
    ledDireccion = busy ? dir_lat : direccionGiro;
  end

endmodule
